// File: rtl/lemmings_pkg.sv
// Shared state encoding and default sizing for the parametrised Lemmings core.
package lemmings_pkg;

  typedef enum logic [2:0] {
    WALK_L = 3'd0,
    WALK_R = 3'd1,
    FALL_L = 3'd2,
    DIG_L  = 3'd3,
    FALL_R = 3'd4,
    DIG_R  = 3'd5,
    SPLAT  = 3'd6
  } state_t;

  localparam int SPLAT_LIMIT_DEF = 20;
  localparam int CNT_W_DEF       = 5;

  function automatic logic is_fall(input state_t s);
    return (s == FALL_L) || (s == FALL_R);
  endfunction

endpackage

// File: rtl/lemmings_fall_ctr.sv
// Saturating fall-duration counter; flags when the count has reached LIMIT.
module lemmings_fall_ctr #(
  parameter int CNT_W = 5,
  parameter int LIMIT = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             limit_reached
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_count;

  // Holds at CNT_MAX rather than wrapping, so a long fall keeps reporting the limit.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (inc && (r_count != CNT_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count         = r_count;
  assign limit_reached = (int'(r_count) >= LIMIT);

endmodule

// File: rtl/lemmings4_param.sv
// Lemmings walker/digger/faller FSM with fall counter and terminal SPLAT state.
module lemmings4_param
  import lemmings_pkg::*;
#(
  parameter int SPLAT_LIMIT = SPLAT_LIMIT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bump_left,
  input  logic             bump_right,
  input  logic             ground,
  input  logic             dig,
  input  logic             revive,
  output logic             walk_left,
  output logic             walk_right,
  output logic             aaah,
  output logic             digging,
  output logic             splat,
  output logic [CNT_W-1:0] fall_cnt
);

  if ((2 ** CNT_W) - 1 < SPLAT_LIMIT) begin : g_cnt_w_too_small
    $error("lemmings4_param: CNT_W=%0d cannot represent SPLAT_LIMIT=%0d", CNT_W, SPLAT_LIMIT);
  end

  state_t r_state;
  state_t w_next;
  logic   w_limit;
  logic   w_clear;
  logic   w_inc;

  always_ff @(posedge clk) begin
    if (reset) r_state <= WALK_L;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      WALK_L: begin
        if (!ground)        w_next = FALL_L;
        else if (dig)       w_next = DIG_L;
        else if (bump_left) w_next = WALK_R;
      end
      WALK_R: begin
        if (!ground)         w_next = FALL_R;
        else if (dig)        w_next = DIG_R;
        else if (bump_right) w_next = WALK_L;
      end
      DIG_L:  if (!ground) w_next = FALL_L;
      DIG_R:  if (!ground) w_next = FALL_R;
      // Landing with count >= limit means more than SPLAT_LIMIT aaah cycles elapsed.
      FALL_L: if (ground) w_next = w_limit ? SPLAT : WALK_L;
      FALL_R: if (ground) w_next = w_limit ? SPLAT : WALK_R;
      SPLAT:  if (revive) w_next = WALK_L;
      default: w_next = WALK_L;
    endcase
  end

  assign w_clear = !is_fall(w_next);
  assign w_inc   = is_fall(r_state) && !ground;

  lemmings_fall_ctr #(
    .CNT_W(CNT_W),
    .LIMIT(SPLAT_LIMIT)
  ) u_fall_ctr (
    .clk          (clk),
    .reset        (reset),
    .clear        (w_clear),
    .inc          (w_inc),
    .count        (fall_cnt),
    .limit_reached(w_limit)
  );

  assign walk_left  = (r_state == WALK_L);
  assign walk_right = (r_state == WALK_R);
  assign aaah       = is_fall(r_state);
  assign digging    = (r_state == DIG_L) || (r_state == DIG_R);
  assign splat      = (r_state == SPLAT);

endmodule

// File: doc/lemmings4_param.md
Name: lemmings4_param

Overview:
- Parametrised successor to the six-state Lemmings walker/faller/digger FSM.
- Adds a fall-duration counter with a configurable splatter threshold.
- Adds a terminal SPLAT state, exited only by reset or an explicit `revive` input.
- Sits in the FSM exercise set as the reusable Lemmings core; exports the live fall count for scoreboarding.

Parameters:
- SPLAT_LIMIT, 20: maximum number of falling cycles (cycles with aaah=1) that still permit a safe landing.
- CNT_W, 5: width of fall counter. Must satisfy 2^CNT_W-1 >= SPLAT_LIMIT; checked by elaboration-time assertion.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- bump_left  in  1  obstacle on left
- bump_right  in  1  obstacle on right
- ground  in  1  ground present under lemming
- dig  in  1  dig command
- revive  in  1  leave SPLAT; ignored in every other state
- walk_left  out  1  state==WALK_L
- walk_right  out  1  state==WALK_R
- aaah  out  1  state in {FALL_L, FALL_R}
- digging  out  1  state in {DIG_L, DIG_R}
- splat  out  1  state==SPLAT
- fall_cnt  out  CNT_W  completed falling cycles in the current fall; 0 outside FALL states

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, port reset, sampled on posedge clk only.
- Reset:
  - state=WALK_L, fall_cnt=0.
  - Outputs after the reset edge: walk_left=1; all other flags 0; fall_cnt=0.
  - Reset wins over every other input, including mid-fall and in SPLAT.
- Moore outputs: all outputs are decoded from registered state and counter only. No input-to-output combinational path.
- States: WALK_L, WALK_R, FALL_L, FALL_R, DIG_L, DIG_R, SPLAT.
- Transition priority, per state:
  - WALK_L:
    - !ground -> FALL_L
    - else dig -> DIG_L
    - else bump_left -> WALK_R
    - else stay
    - bump_right is ignored. Both bumps together -> WALK_R.
  - WALK_R: mirror of WALK_L (bump_right -> WALK_L; both bumps -> WALK_L).
  - DIG_L / DIG_R: !ground -> FALL_L / FALL_R; else stay. dig and bumps are ignored.
  - FALL_L / FALL_R:
    - !ground -> stay.
    - ground -> SPLAT if fall_cnt >= SPLAT_LIMIT.
    - ground -> WALK_L / WALK_R otherwise.
    - dig and bumps are ignored.
  - SPLAT: revive -> WALK_L; else stay. All other inputs are ignored.
- Fall counter:
  - Next value is 0 whenever the next state is not FALL_x.
  - In FALL_x with !ground: fall_cnt <= min(fall_cnt+1, 2^CNT_W-1), saturating with no wrap.
  - Entering FALL from WALK/DIG: fall_cnt=0 in the first falling cycle.
  - Landing cycle: total aaah cycles = fall_cnt+1. Splat iff that exceeds SPLAT_LIMIT.
  - Boundary cases:
    - Exactly SPLAT_LIMIT aaah cycles -> safe landing.
    - SPLAT_LIMIT+1 aaah cycles -> SPLAT.
  - Saturation at max must never turn a splat into a safe landing.
- Direction is preserved across fall and dig: FALL_L lands into WALK_L; FALL_R lands into WALK_R.
- Unreachable encodings recover to WALK_L on the next clock.

Decomposition:
- lemmings_pkg holds:
  - the state typedef/encoding (3-bit, WALK_L=0, WALK_R=1, FALL_L=2, DIG_L=3, FALL_R=4, DIG_R=5, SPLAT=6)
  - default constants SPLAT_LIMIT_DEF=20 and CNT_W_DEF=5.
- One sub-module: lemmings_fall_ctr.
  - Parametrised saturating up-counter with inputs clear and inc.
  - Outputs: count, and limit_reached (count >= LIMIT).
  - The FSM uses limit_reached for the landing decision.

Test Plan:
- Reset, then ground=1 with no bumps for 5 cycles -> walk_left=1 on every cycle; other outputs 0; fall_cnt=0.
- Walking left, pulse bump_left=bump_right=1 together -> walk_right=1 next cycle. Then bump_right -> walk_left=1.
- Walking right, ground=0 for 20 cycles, then ground=1:
  - aaah=1 for exactly 20 cycles
  - fall_cnt reads 0..19
  - then walk_right=1, splat=0.
- Walking left, ground=0 for 21 cycles, then ground=1 -> splat=1 and all other flags 0. Hold revive=0 plus random inputs for 10 cycles -> splat stays 1. revive=1 -> walk_left=1.
- dig=1 while walking left -> digging=1. Bumps are ignored while digging. ground=0 -> aaah=1 (FALL_L). ground=1 after 3 cycles -> walk_left=1.
- Assert reset during cycle 10 of a fall -> walk_left=1 and fall_cnt=0 next cycle. Repeat with SPLAT_LIMIT=3, CNT_W=2: a 4-cycle fall splats; a 100-cycle fall (counter saturated at 3) still splats.
